// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// S1 registers bit/group generate-propagate, S2 resolves carries and flags.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] bb;
  logic             c0_d;
  logic [WIDTH-1:0] p_d, g_d;
  logic [NG-1:0]    pg_d, gg_d;
  logic             gt;

  logic [WIDTH-1:0] p_q, g_q;
  logic [NG-1:0]    pg_q, gg_q;
  logic             am_q, bm_q, c0_q;
  logic             s1v_q;

  logic [NG:0]      gc;
  logic             ct, ca;
  logic [WIDTH-1:0] bc;
  logic             bt, ba;

  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;
  logic             ov_q;

  logic             s2_en, accept;

  assign bb   = sub ? ~b : b;
  assign c0_d = sub | cin;
  assign p_d  = a ^ bb;
  assign g_d  = a & bb;

  always_comb begin
    pg_d = '0;
    gg_d = '0;
    gt   = 1'b0;
    for (int j = 0; j < NG; j++) begin
      pg_d[j] = &p_d[j*GROUP +: GROUP];
      for (int i = 0; i < GROUP; i++) begin
        gt = g_d[j*GROUP+i];
        for (int k = i + 1; k < GROUP; k++)
          gt = gt & p_d[j*GROUP+k];
        gg_d[j] = gg_d[j] | gt;
      end
    end
  end

  // Group carries flattened to sum-of-products from c0.
  always_comb begin
    gc    = '0;
    ct    = 1'b0;
    ca    = 1'b0;
    gc[0] = c0_q;
    for (int j = 0; j < NG; j++) begin
      ct = c0_q;
      for (int m = 0; m <= j; m++)
        ct = ct & pg_q[m];
      ca = ct;
      for (int m = 0; m <= j; m++) begin
        ct = gg_q[m];
        for (int n = m + 1; n <= j; n++)
          ct = ct & pg_q[n];
        ca = ca | ct;
      end
      gc[j+1] = ca;
    end
  end

  always_comb begin
    bc = '0;
    bt = 1'b0;
    ba = 1'b0;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        bt = gc[j];
        for (int k = 0; k < i; k++)
          bt = bt & p_q[j*GROUP+k];
        ba = bt;
        for (int t = 0; t < i; t++) begin
          bt = g_q[j*GROUP+t];
          for (int k = t + 1; k < i; k++)
            bt = bt & p_q[j*GROUP+k];
          ba = ba | bt;
        end
        bc[j*GROUP+i] = ba;
      end
    end
  end

  assign sum_d  = p_q ^ bc;
  assign cout_d = gc[NG];
  assign ovf_d  = (am_q == bm_q) &&
                  (sum_d[WIDTH-1] != am_q);
  assign zero_d = ~|sum_d;

  assign s2_en    = !ov_q || out_ready;
  assign in_ready = !s1v_q || s2_en;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      g_q    <= '0;
      pg_q   <= '0;
      gg_q   <= '0;
      am_q   <= 1'b0;
      bm_q   <= 1'b0;
      c0_q   <= 1'b0;
      s1v_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        p_q   <= p_d;
        g_q   <= g_d;
        pg_q  <= pg_d;
        gg_q  <= gg_d;
        am_q  <= a[WIDTH-1];
        bm_q  <= bb[WIDTH-1];
        c0_q  <= c0_d;
        s1v_q <= accept;
      end
      if (s2_en) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        ov_q   <= s1v_q;
      end
    end
  end

  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: arithmetic model plus
// in-order result queue, checked every negedge.
module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, ovf, zero;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int hand = 0;

  typedef struct {
    logic [15:0] s;
    logic        c, o, z;
    int          t;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  function automatic exp_t model(
    input logic [15:0] x, input logic [15:0] y,
    input logic ci, input logic s
  );
    exp_t        e;
    logic [15:0] yy;
    logic [16:0] full;
    int          c0, r;
    yy   = s ? ~y : y;
    c0   = (s || ci) ? 1 : 0;
    full = {1'b0, x} + {1'b0, yy} + 17'(c0);
    r    = int'($signed(x)) + int'($signed(yy)) + c0;
    e.s  = full[15:0];
    e.c  = full[16];
    e.o  = (r > 32767) || (r < -32768);
    e.z  = (full[15:0] == 16'h0);
    e.t  = 0;
    return e;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_ir, exp_ov;
    exp_t e;
    if (rst) begin
      q.delete();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out", {out_valid, sum, cout, ovf, zero}, 0);
    end else begin
      exp_ir = (q.size() < 2) || out_ready;
      exp_ov = (q.size() > 0) && (q[0].t + 2 <= cyc);
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("sum", 32'(sum), 32'(q[0].s));
        chk("flags", {cout, ovf, zero},
            {q[0].c, q[0].o, q[0].z});
        if (out_ready) void'(q.pop_front());
      end
      if (out_valid && out_ready) hand++;
      if (in_valid && exp_ir) begin
        e   = model(a, b, cin, sub);
        e.t = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic drive(input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic s);
    in_valid = 1'b1;
    a = x; b = y; cin = ci; sub = s;
  endtask

  task automatic single(input string n,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic s,
                        input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
    @(posedge clk); #1 drive(x, y, ci, s);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk(n, {out_valid, sum, cout, ovf, zero},
        {1'b1, es, ec, eo, ez});
  endtask

  initial begin
    #100000;
    nerr++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        m;
    logic [15:0] ox [4];
    logic [15:0] oy [4];
    int          idx, h0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    m = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("model_wrap", {m.s, m.c, m.o, m.z}, {16'h0000, 3'b101});
    m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("model_ovf", {m.s, m.c, m.o, m.z}, {16'h8000, 3'b010});
    m = model(16'h0003, 16'h0005, 1'b0, 1'b1);
    chk("model_sub", {m.s, m.c, m.o, m.z}, {16'hFFFE, 3'b000});
    m = model(16'h8000, 16'h0001, 1'b1, 1'b1);
    chk("model_subovf", {m.s, m.c, m.o, m.z}, {16'h7FFF, 3'b110});

    #1;
    chk("reset_lit", {in_ready, out_valid}, 2'b10);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    single("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0,
           16'h0000, 1'b1, 1'b0, 1'b1);
    single("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
           16'h8000, 1'b0, 1'b1, 1'b0);
    single("cin", 16'h1234, 16'h0F0F, 1'b1, 1'b0,
           16'h2144, 1'b0, 1'b0, 1'b0);
    single("sub", 16'h0003, 16'h0005, 1'b0, 1'b1,
           16'hFFFE, 1'b0, 1'b0, 1'b0);
    single("sub_cin", 16'h0003, 16'h0005, 1'b1, 1'b1,
           16'hFFFE, 1'b0, 1'b0, 1'b0);
    single("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1,
           16'h7FFF, 1'b1, 1'b1, 1'b0);
    single("subovf_cin", 16'h8000, 16'h0001, 1'b1, 1'b1,
           16'h7FFF, 1'b1, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1 h0 = hand;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("stream_count", 32'(hand - h0), 8);

    for (int i = 0; i < 4; i++) begin
      ox[i] = 16'($urandom);
      oy[i] = 16'($urandom);
    end
    h0  = hand;
    idx = 0;
    out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      drive(ox[idx], oy[idx], 1'b0, idx[0]);
      #1 if (in_ready) idx++;
    end
    chk("bp_accepts", 32'(idx), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("bp_count", 32'(hand - h0), 2);

    out_ready = 1'b0;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h3333, 16'h4444, 1'b0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("full_before_rst", {out_valid, in_ready}, 2'b10);
    #1 rst = 1'b1;
    #1 chk("rst_async", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    h0 = hand;
    repeat (3) @(posedge clk);
    #1 chk("no_stale", 32'(hand - h0), 0);
    single("after_rst", 16'h1234, 16'h0F0F, 1'b1, 1'b0,
           16'h2144, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
